// File: rtl/neokeon_decrypt_core_pkg.sv
// ============================================================================
// neokeon_decrypt_core_pkg : shared types, round constants and word helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package neokeon_decrypt_core_pkg;

    localparam int NR    = 16;
    localparam int CNT_W = $clog2(NR + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYGEN = 2'd1,
        ROUND  = 2'd2,
        FINAL  = 2'd3
    } state_e;

    // RC[0] sits in the least significant byte.
    localparam logic [8*(NR+1)-1:0] c_rc_table = {
        8'hD4, 8'h6A, 8'h35, 8'h97, 8'hC6, 8'h63, 8'hBC, 8'h5E, 8'h2F,
        8'h9A, 8'h4D, 8'hAB, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h80
    };

    function automatic logic [7:0] rc_byte(input cnt_t idx);
        return c_rc_table[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [127:0] add_rc(input logic [127:0] s, input logic [7:0] rc);
        return s ^ {24'h0, rc, 96'h0};
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] pi1(input logic [127:0] s);
        return {s[127:96], rotl32(s[95:64], 1), rotl32(s[63:32], 5), rotl32(s[31:0], 2)};
    endfunction

    function automatic logic [127:0] pi2(input logic [127:0] s);
        return {s[127:96], rotl32(s[95:64], 31), rotl32(s[63:32], 27), rotl32(s[31:0], 30)};
    endfunction

    function automatic logic [127:0] gamma(input logic [127:0] s);
        logic [31:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = s;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        t  = a3;
        a3 = a0;
        a0 = t;
        a2 = a2 ^ a0 ^ a1 ^ a3;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        return {a0, a1, a2, a3};
    endfunction

endpackage

`default_nettype wire

// File: rtl/neokeon_dec_round.sv
// ============================================================================
// neokeon_dec_round : one combinational inverse round (Theta, RC, Pi1, Gamma, Pi2)
// Rev 1.0
// ============================================================================
`default_nettype none

module neokeon_dec_round
    import neokeon_decrypt_core_pkg::*;
(
    input  logic [127:0] i_key,
    input  logic [127:0] i_state,
    input  logic [7:0]   i_rc,
    output logic [127:0] o_state
);

    logic [127:0] w_theta;

    neokeon_theta u_theta (
        .i_key  (i_key),
        .i_data (i_state),
        .o_data (w_theta)
    );

    assign o_state = pi2(gamma(pi1(add_rc(w_theta, i_rc))));

endmodule

`default_nettype wire

// File: rtl/neokeon_theta.sv
// ============================================================================
// neokeon_theta : Noekeon linear mixing layer with key addition (combinational)
// Rev 1.0
// ============================================================================
`default_nettype none

module neokeon_theta
    import neokeon_decrypt_core_pkg::*;
(
    input  logic [127:0] i_key,
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);

    logic [31:0] w_t0, w_t1;
    logic [31:0] w_a0, w_a1, w_a2, w_a3;

    function automatic logic [31:0] mix(input logic [31:0] t);
        return t ^ rotl32(t, 8) ^ rotl32(t, 24);
    endfunction

    assign w_t0 = mix(i_data[127:96] ^ i_data[63:32]);
    assign w_a0 = i_data[127:96] ^ i_key[127:96];
    assign w_a1 = i_data[95:64]  ^ w_t0 ^ i_key[95:64];
    assign w_a2 = i_data[63:32]  ^ i_key[63:32];
    assign w_a3 = i_data[31:0]   ^ w_t0 ^ i_key[31:0];
    assign w_t1 = mix(w_a1 ^ w_a3);

    assign o_data = {w_a0 ^ w_t1, w_a1, w_a2 ^ w_t1, w_a3};

endmodule

`default_nettype wire

// File: rtl/neokeon_decrypt_core.sv
// ============================================================================
// neokeon_decrypt_core : iterative Noekeon-128 direct-key decryption, 19 cycles/block
// Rev 1.0
// ============================================================================
`default_nettype none

module neokeon_decrypt_core
    import neokeon_decrypt_core_pkg::*;
(
    input  logic         inClk,
    input  logic         inReset,
    input  logic         inStart,
    input  logic [127:0] inDataKey,
    input  logic [127:0] inDataCipher,
    output logic [127:0] outDataPlain,
    output logic         outValid,
    output logic         outBusy
);

    state_e       state_q, state_d;
    cnt_t         cnt_q, cnt_d;
    logic [127:0] key_q, key_d;
    logic [127:0] data_q, data_d;
    logic [127:0] plain_q, plain_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;

    logic [127:0] w_theta_key, w_theta_in, w_theta_out, w_round_out;

    // Shared Theta: derives DK from WK in KEYGEN, finishes the block in FINAL.
    assign w_theta_key = (state_q == KEYGEN) ? '0 : key_q;
    assign w_theta_in  = (state_q == KEYGEN) ? key_q : data_q;

    neokeon_theta u_theta (
        .i_key  (w_theta_key),
        .i_data (w_theta_in),
        .o_data (w_theta_out)
    );

    neokeon_dec_round u_round (
        .i_key   (key_q),
        .i_state (data_q),
        .i_rc    (rc_byte(cnt_q)),
        .o_state (w_round_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        data_d  = data_q;
        plain_d = plain_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (inStart) begin
                    key_d   = inDataKey;
                    data_d  = inDataCipher;
                    busy_d  = 1'b1;
                    state_d = KEYGEN;
                end
            end
            KEYGEN: begin
                key_d   = w_theta_out;
                cnt_d   = cnt_t'(NR);
                state_d = ROUND;
            end
            ROUND: begin
                data_d = w_round_out;
                cnt_d  = cnt_q - cnt_t'(1);
                if (cnt_q == cnt_t'(1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                plain_d = add_rc(w_theta_out, rc_byte(cnt_t'(0)));
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            data_q  <= '0;
            plain_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            data_q  <= data_d;
            plain_q <= plain_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign outDataPlain = plain_q;
    assign outValid     = valid_q;
    assign outBusy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_neokeon_decrypt_core.sv
// ============================================================================
// tb_neokeon_decrypt_core : scoreboard bench, expected plaintexts from an encryption model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_neokeon_decrypt_core;

    logic         inClk;
    logic         inReset;
    logic         inStart;
    logic [127:0] inDataKey;
    logic [127:0] inDataCipher;
    logic [127:0] outDataPlain;
    logic         outValid;
    logic         outBusy;

    neokeon_decrypt_core dut (
        .inClk        (inClk),
        .inReset      (inReset),
        .inStart      (inStart),
        .inDataKey    (inDataKey),
        .inDataCipher (inDataCipher),
        .outDataPlain (outDataPlain),
        .outValid     (outValid),
        .outBusy      (outBusy)
    );

    typedef struct {
        logic [127:0] plain;
        int           at;
    } exp_t;

    exp_t         sb[$];
    int           checks     = 0;
    int           failures   = 0;
    int           cyc        = 0;
    int           busy_from  = 1;
    int           busy_to    = 0;
    int           next_free  = 0;
    logic [127:0] last_plain = '0;
    logic [7:0]   rc_m [17];

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;
    always @(posedge inClk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic ok, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: Noekeon encryption, direct-key ----------------
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] m_theta(input logic [127:0] k, input logic [127:0] s);
        logic [31:0] a [4];
        logic [31:0] kk [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            a[i]  = s[127-32*i -: 32];
            kk[i] = k[127-32*i -: 32];
        end
        t = a[0] ^ a[2];
        t = t ^ rl(t, 8) ^ rl(t, 24);
        a[1] ^= t;
        a[3] ^= t;
        for (int i = 0; i < 4; i++) a[i] ^= kk[i];
        t = a[1] ^ a[3];
        t = t ^ rl(t, 8) ^ rl(t, 24);
        a[0] ^= t;
        a[2] ^= t;
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] m_pi(input logic [127:0] s, input logic right);
        logic [31:0] a [4];
        int          amt [4];
        amt = '{0, 1, 5, 2};
        for (int i = 0; i < 4; i++) begin
            a[i] = s[127-32*i -: 32];
            if (amt[i] != 0) a[i] = rl(a[i], right ? 32 - amt[i] : amt[i]);
        end
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] m_gamma(input logic [127:0] s);
        logic [31:0] a [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) a[i] = s[127-32*i -: 32];
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        t = a[3]; a[3] = a[0]; a[0] = t;
        a[2] ^= a[0] ^ a[1] ^ a[3];
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] s;
        s = p;
        for (int r = 0; r < 16; r++) begin
            s[103:96] ^= rc_m[r];
            s = m_theta(k, s);
            s = m_pi(m_gamma(m_pi(s, 1'b0)), 1'b1);
        end
        s[103:96] ^= rc_m[16];
        return m_theta(k, s);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge inClk) begin
        exp_t e;
        logic exp_busy;
        exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
        if (outValid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1'b0, 128'(outValid), 128'd0);
            end else begin
                e = sb.pop_front();
                chk("valid_cycle", cyc == e.at, 128'(cyc), 128'(e.at));
                chk("plain", outDataPlain == e.plain, outDataPlain, e.plain);
                last_plain = e.plain;
            end
        end else begin
            if (sb.size() > 0 && sb[0].at < cyc) begin
                chk("valid_timeout", 1'b0, 128'(cyc), 128'(sb[0].at));
                void'(sb.pop_front());
            end
            chk("plain_hold", outDataPlain == last_plain, outDataPlain, last_plain);
        end
        chk("busy", outBusy == exp_busy, 128'(outBusy), 128'(exp_busy));
    end

    // ---------------- driver ----------------
    task automatic drive(input logic st, input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] e, output logic acc);
        exp_t x;
        @(negedge inClk);
        #2;
        inStart      = st;
        inDataKey    = k;
        inDataCipher = c;
        acc          = 1'b0;
        if (st && (cyc + 1) >= next_free) begin
            acc       = 1'b1;
            x.plain   = e;
            x.at      = cyc + 19;
            sb.push_back(x);
            busy_from = cyc + 1;
            busy_to   = cyc + 18;
            next_free = cyc + 20;
        end
    endtask

    task automatic issue(input logic [127:0] k, input logic [127:0] c, input logic [127:0] e);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 40) begin
            drive(1'b1, k, c, e, acc);
            n++;
        end
        chk("accept", acc, 128'(n), 128'd20);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) drive(1'b0, '0, '0, '0, acc);
    endtask

    task automatic do_reset(input int n);
        @(negedge inClk);
        #2;
        inReset    = 1'b1;
        inStart    = 1'b0;
        sb.delete();
        busy_from  = 1;
        busy_to    = 0;
        next_free  = 0;
        last_plain = '0;
        repeat (n) @(negedge inClk);
        #2;
        inReset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, p, c;
        logic         acc;
        rc_m[0] = 8'h80;
        for (int i = 1; i < 17; i++)
            rc_m[i] = {rc_m[i-1][6:0], 1'b0} ^ (rc_m[i-1][7] ? 8'h1B : 8'h00);

        inReset      = 1'b0;
        inStart      = 1'b0;
        inDataKey    = '0;
        inDataCipher = '0;
        #1 inReset = 1'b1;
        do_reset(3);
        idle(2);

        issue(128'h0, 128'hb1656851699e29fa24b70148503d2dfc, 128'h0);
        idle(22);
        issue({128{1'b1}}, 128'h2a78421b87c7d0924f26113f1d1349b2, {128{1'b1}});
        idle(22);
        issue(128'hb1656851699e29fa24b70148503d2dfc, 128'he2f687e07b75660ffc372233bc47532c,
              128'h2a78421b87c7d0924f26113f1d1349b2);
        idle(22);

        // Abort mid-run, then reissue the same block.
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        c = m_encrypt(k, p);
        issue(k, c, p);
        idle(9);
        do_reset(2);
        issue(k, c, p);
        idle(22);

        // Start held high; inputs swap to a second block while the first is in flight.
        issue(128'hb1656851699e29fa24b70148503d2dfc, 128'he2f687e07b75660ffc372233bc47532c,
              128'h2a78421b87c7d0924f26113f1d1349b2);
        repeat (4) drive(1'b1, 128'hb1656851699e29fa24b70148503d2dfc,
                         128'he2f687e07b75660ffc372233bc47532c,
                         128'h2a78421b87c7d0924f26113f1d1349b2, acc);
        issue({128{1'b1}}, 128'h2a78421b87c7d0924f26113f1d1349b2, {128{1'b1}});
        idle(22);

        repeat (100) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            c = m_encrypt(k, p);
            issue(k, c, p);
        end
        idle(25);

        chk("scoreboard_empty", sb.size() == 0, 128'(sb.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
